imem_loadable: RTL

IMEM_LOADABLE -- requirements
Module: imem_loadable

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_loader.sv | 55 +++++
 rtl/imem_loadable.sv | 89 ++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared defaults and FSM state encoding for the loadable instruction memory
package imem_pkg;
    localparam int DATA_W_DEF = 32;
    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = '0;
    typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_e;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: RUN/LOAD session FSM, write pointer and load_done pulse
//   clk, rst                -- clock, synchronous active-high reset
//   load_start, load_valid  -- session start / word strobe
//   run                     -- FSM is in RUN
//   we, waddr               -- memory write enable and word address
//   load_done               -- one-cycle pulse after the last word is written
module imem_loader import imem_pkg::*; #(
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    output logic                     run,
    output logic                     we,
    output logic [$clog2(DEPTH)-1:0] waddr,
    output logic                     load_done
);
    localparam int AW = $clog2(DEPTH);
    state_e state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic done_q, done_d;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        we      = 1'b0;
        if (load_start) begin
            state_d = LOAD;
            ptr_d   = '0;
        end else if (state_q == LOAD && load_valid) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            // DEPTH is a power of two, so the last word has an all-ones pointer
            if (&ptr_q) begin
                state_d = RUN;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end
    assign run       = (state_q == RUN);
    assign waddr     = ptr_q;
    assign load_done = done_q;
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory with 1-cycle fetch port and program-load session
//   clk, rst                          -- clock, synchronous active-high reset
//   req, addr, stall                  -- fetch request, byte address, response hold
//   fetch_ready, resp_valid, inst     -- fetch status and response
//   fault                             -- address fault (only with IMEM_FAULT_EN)
//   load_start, load_valid, load_data -- program-load session inputs
//   load_done                         -- pulse after the last word is written
// Optional: define IMEM_FAULT_EN to flag misaligned / out-of-range fetches.
module imem_loadable import imem_pkg::*; #(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = 128,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    output logic              fetch_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] inst,
    output logic              fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_done
);
    localparam int AW = $clog2(DEPTH);
    logic          run, we, bad;
    logic [AW-1:0] waddr, ridx;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};
    logic              valid_q, valid_d, fault_q, fault_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    imem_loader #(.DEPTH(DEPTH)) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .run        (run),
        .we         (we),
        .waddr      (waddr),
        .load_done  (load_done)
    );
    assign ridx = addr[AW+1:2];
`ifdef IMEM_FAULT_EN
    assign bad = (addr[1:0] != 2'b00) || (addr[ADDR_W-1:AW+2] != '0);
`else
    logic unused_addr;
    assign bad         = 1'b0;
    assign unused_addr = ^{addr[1:0], addr[ADDR_W-1:AW+2]};
`endif
    assign rd = bad ? NOP_WORD : mem_q[ridx];
    // Memory is deliberately outside reset so a reset never loses a loaded program
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= load_data;
    end
    // A load session (entering or ongoing) drops fetches and overrides stall
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        if (!run || load_start) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = req;
            if (req) begin
                inst_d  = rd;
                fault_d = bad;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end
    assign fetch_ready = run;
    assign resp_valid  = valid_q;
    assign inst        = inst_q;
    assign fault       = fault_q;
endmodule
